// File: rtl/motor_movimiento.sv
// 2048 move engine: slides and merges an NxN board toward one of four edges.
// Latency: N+1 cycles from an accepted start to the done pulse, one line per cycle.
// Backpressure: none; start is only honoured in IDLE and is ignored while busy.
module motor_movimiento #(
   parameter int N  = 4,
   parameter int W  = 16,
   parameter int SW = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       dir,
   input  logic [N*N*W-1:0] board_in,
   output logic [N*N*W-1:0] board_out,
   output logic             busy,
   output logic             done,
   output logic             moved,
   output logic [SW-1:0]    score_delta,
   output logic             overflow
);

   localparam int KW  = $clog2(N);
   localparam int CW  = $clog2(N + 1);
   // A line yields at most N/2 merges, each below 2^W.
   localparam int LSW = W + $clog2(N) + 1;
   localparam int AW  = ((SW > LSW) ? SW : LSW) + 1;
   // Tiles above this value would double past 2^(W-1) and must not merge.
   localparam logic [W-1:0]  HALF = W'(1) << (W - 2);
   localparam logic [SW-1:0] SMAX = '1;

   typedef enum logic [1:0] {IDLE, LINE, DONE} state_t;

   state_t             state_q, state_d;
   logic [N*N*W-1:0]   work_q, work_nxt;
   logic [1:0]         dir_q;
   logic [KW-1:0]      k_q;
   logic               acc_moved_q, acc_ovf_q;
   logic [SW-1:0]      acc_score_q;

   logic               last_line;
   int                 idx [N];
   logic [W-1:0]       line_in  [N];
   logic [W-1:0]       comp     [N+1];
   logic [W-1:0]       line_out [N];
   logic [CW-1:0]      cnt, o;
   logic               skip;
   logic [LSW-1:0]     line_score;
   logic               line_ovf, line_moved;
   logic [AW-1:0]      score_sum;
   logic [SW-1:0]      score_sat;

   // Flat cell index of element i of line kk; element 0 sits on the target edge.
   function automatic int cell_idx(input logic [1:0] d, input int kk, input int i);
      case (d)
         2'b00:   return kk * N + (N - 1 - i);
         2'b01:   return kk * N + i;
         2'b10:   return i * N + kk;
         default: return (N - 1 - i) * N + kk;
      endcase
   endfunction

   assign last_line = (k_q == KW'(N - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: IDLE waits for start, LINE runs N cycles, DONE lasts one.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = LINE;
         LINE:    if (last_line) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Current line: gather, compact, merge pairwise, scatter back into the work board.
   always_comb begin
      work_nxt   = work_q;
      cnt        = '0;
      o          = '0;
      skip       = 1'b0;
      line_score = '0;
      line_ovf   = 1'b0;
      line_moved = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx[i]      = cell_idx(dir_q, int'(k_q), i);
         line_in[i]  = work_q[idx[i]*W +: W];
         line_out[i] = '0;
      end
      for (int i = 0; i <= N; i++) comp[i] = '0;
      for (int i = 0; i < N; i++) begin
         if (line_in[i] != '0) begin
            comp[cnt] = line_in[i];
            cnt       = cnt + CW'(1);
         end
      end
      // comp[N] is always zero, so the last element never finds a partner.
      for (int j = 0; j < N; j++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (comp[j] != '0) begin
            if (comp[j] == comp[j+1] && comp[j] > HALF) begin
               line_out[o] = comp[j];
               line_ovf    = 1'b1;
            end else if (comp[j] == comp[j+1]) begin
               line_out[o] = comp[j] << 1;
               line_score  = line_score + (LSW'(comp[j]) << 1);
               skip        = 1'b1;
            end else begin
               line_out[o] = comp[j];
            end
            o = o + CW'(1);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (line_out[i] != line_in[i]) line_moved = 1'b1;
         work_nxt[idx[i]*W +: W] = line_out[i];
      end
   end

   // Saturating score accumulation.
   always_comb begin
      score_sum = AW'(acc_score_q) + AW'(line_score);
      score_sat = (score_sum > AW'(SMAX)) ? SMAX : score_sum[SW-1:0];
   end

   // Datapath and registered outputs; results publish on the edge entering DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         work_q      <= '0;
         dir_q       <= 2'b00;
         k_q         <= '0;
         acc_moved_q <= 1'b0;
         acc_score_q <= '0;
         acc_ovf_q   <= 1'b0;
         board_out   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         moved       <= 1'b0;
         score_delta <= '0;
         overflow    <= 1'b0;
      end else begin
         busy <= (state_d != IDLE);
         done <= (state_d == DONE);
         case (state_q)
            IDLE: begin
               if (start) begin
                  work_q      <= board_in;
                  dir_q       <= dir;
                  k_q         <= '0;
                  acc_moved_q <= 1'b0;
                  acc_score_q <= '0;
                  acc_ovf_q   <= 1'b0;
               end
            end
            LINE: begin
               work_q      <= work_nxt;
               acc_moved_q <= acc_moved_q | line_moved;
               acc_score_q <= score_sat;
               acc_ovf_q   <= acc_ovf_q | line_ovf;
               k_q         <= k_q + KW'(1);
               if (last_line) begin
                  board_out   <= work_nxt;
                  moved       <= acc_moved_q | line_moved;
                  score_delta <= score_sat;
                  overflow    <= acc_ovf_q | line_ovf;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_motor_movimiento.sv
// Directed bench for the move engine: one W=16 instance and one W=4 instance.
// Results are compared against hand-computed boards, scores and flags.
// Handshake timing (latency, throughput, ignored starts, reset) is checked too.
module tb_motor_movimiento;

   logic         clk = 1'b0;
   logic         rst, start, busy, done, moved, overflow;
   logic [1:0]   dir;
   logic [255:0] board_in, board_out;
   logic [23:0]  score_delta;

   logic         start2, busy2, done2, moved2, ovf2;
   logic [1:0]   dir2;
   logic [63:0]  board_in2, board_out2;
   logic [23:0]  score2;

   int nchecks = 0;
   int nerrs   = 0;

   motor_movimiento #(.N(4), .W(16), .SW(24)) u_dut (
      .clk(clk), .rst(rst), .start(start), .dir(dir), .board_in(board_in),
      .board_out(board_out), .busy(busy), .done(done), .moved(moved),
      .score_delta(score_delta), .overflow(overflow)
   );

   motor_movimiento #(.N(4), .W(4), .SW(24)) u_dut_w4 (
      .clk(clk), .rst(rst), .start(start2), .dir(dir2), .board_in(board_in2),
      .board_out(board_out2), .busy(busy2), .done(done2), .moved(moved2),
      .score_delta(score2), .overflow(ovf2)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] put(input logic [255:0] b, input int r, input int c,
                                        input logic [15:0] v);
      b[(r*4+c)*16 +: 16] = v;
      return b;
   endfunction

   function automatic logic [63:0] put4(input logic [63:0] b, input int r, input int c,
                                        input logic [3:0] v);
      b[(r*4+c)*4 +: 4] = v;
      return b;
   endfunction

   // Issue one move on the W=16 instance; returns cycles from acceptance to done.
   task automatic run_move(input logic [1:0] d, input logic [255:0] b, output int lat);
      @(negedge clk);
      start = 1'b1; dir = d; board_in = b;
      @(negedge clk);
      start = 1'b0; board_in = '1;
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!done) check("done_timeout", 256'(done), 256'(1));
   endtask

   logic [255:0] b, exp;
   logic [63:0]  b2, got2;
   int           lat, n1, n2, ndone, ovf_seen, score_seen, moved_seen;

   initial begin
      rst = 1'b1; start = 1'b0; dir = 2'b00; board_in = '0;
      start2 = 1'b0; dir2 = 2'b00; board_in2 = '0;
      repeat (3) @(negedge clk);
      check("rst_board_out", board_out, 256'(0));
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_done", 256'(done), 256'(0));
      check("rst_moved", 256'(moved), 256'(0));
      check("rst_score", 256'(score_delta), 256'(0));
      check("rst_ovf", 256'(overflow), 256'(0));
      check("rst_busy_w4", 256'(busy2), 256'(0));
      rst = 1'b0;

      // Row 0 [2,2,2,2] right -> [0,0,4,4]
      b = '0;
      for (int c = 0; c < 4; c++) b = put(b, 0, c, 16'd2);
      exp = put(put(256'(0), 0, 2, 16'd4), 0, 3, 16'd4);
      run_move(2'b00, b, lat);
      check("t1_latency", 256'(lat), 256'(5));
      check("t1_board", board_out, exp);
      check("t1_score", 256'(score_delta), 256'(8));
      check("t1_moved", 256'(moved), 256'(1));
      check("t1_ovf", 256'(overflow), 256'(0));
      @(negedge clk);
      check("t1_done_pulse", 256'(done), 256'(0));
      check("t1_busy_idle", 256'(busy), 256'(0));
      check("t1_held", board_out, exp);

      // Row 0 [2,2,4,0] left -> [4,4,0,0]
      b = put(put(put(256'(0), 0, 0, 16'd2), 0, 1, 16'd2), 0, 2, 16'd4);
      exp = put(put(256'(0), 0, 0, 16'd4), 0, 1, 16'd4);
      run_move(2'b01, b, lat);
      check("t2_board", board_out, exp);
      check("t2_score", 256'(score_delta), 256'(4));

      // Column 1 [0,4,0,4]; column 3 full and unmergeable
      b = put(put(256'(0), 1, 1, 16'd4), 3, 1, 16'd4);
      b = put(put(put(put(b, 0, 3, 16'd2), 1, 3, 16'd4), 2, 3, 16'd8), 3, 3, 16'd16);
      exp = put(put(put(put(put(256'(0), 0, 1, 16'd8), 0, 3, 16'd2), 1, 3, 16'd4),
                2, 3, 16'd8), 3, 3, 16'd16);
      run_move(2'b10, b, lat);
      check("t3_up_board", board_out, exp);
      check("t3_up_score", 256'(score_delta), 256'(8));
      exp = put(put(exp, 0, 1, 16'd0), 3, 1, 16'd8);
      run_move(2'b11, b, lat);
      check("t3_down_board", board_out, exp);
      check("t3_down_moved", 256'(moved), 256'(1));

      // Rows [2,4,8,16] right: no-op
      b = '0;
      for (int r = 0; r < 4; r++) begin
         b = put(b, r, 0, 16'd2); b = put(b, r, 1, 16'd4);
         b = put(b, r, 2, 16'd8); b = put(b, r, 3, 16'd16);
      end
      run_move(2'b00, b, lat);
      check("t4_board", board_out, b);
      check("t4_moved", 256'(moved), 256'(0));
      check("t4_score", 256'(score_delta), 256'(0));

      // start held high: one move every N+2 cycles
      b = '0;
      for (int c = 0; c < 4; c++) b = put(b, 0, c, 16'd2);
      exp = put(put(256'(0), 0, 2, 16'd4), 0, 3, 16'd4);
      @(negedge clk);
      start = 1'b1; dir = 2'b00; board_in = b;
      n1 = 0;
      do begin @(negedge clk); n1++; end while (!done && n1 < 20);
      n2 = 0;
      do begin @(negedge clk); n2++; end while (!done && n2 < 20);
      start = 1'b0;
      check("tp_first_latency", 256'(n1), 256'(5));
      check("tp_period", 256'(n2), 256'(6));
      check("tp_board", board_out, exp);
      @(negedge clk);

      // W=4: [8,8,0,0] left must not merge; starts while busy and in DONE ignored
      b2 = put4(put4(64'(0), 0, 0, 4'd8), 0, 1, 4'd8);
      @(negedge clk);
      start2 = 1'b1; dir2 = 2'b01; board_in2 = b2;
      @(negedge clk);
      start2 = 1'b0; board_in2 = put4(put4(64'(0), 0, 0, 4'd2), 0, 1, 4'd2);
      ndone = 0; got2 = '0; ovf_seen = 0; score_seen = -1; moved_seen = -1;
      for (int i = 0; i < 14; i++) begin
         if (done2) begin
            ndone++;
            if (ndone == 1) begin
               got2 = board_out2; ovf_seen = int'(ovf2);
               score_seen = int'(score2); moved_seen = int'(moved2);
            end
         end
         start2 = (i == 1) || done2;
         dir2   = 2'b00;
         @(negedge clk);
      end
      start2 = 1'b0;
      check("ovf_board", 256'(got2), 256'(b2));
      check("ovf_flag", 256'(ovf_seen), 256'(1));
      check("ovf_score", 256'(score_seen), 256'(0));
      check("ovf_moved", 256'(moved_seen), 256'(0));
      check("ovf_single_done", 256'(ndone), 256'(1));

      // Reset in the third LINE cycle discards the move
      @(negedge clk);
      start = 1'b1; dir = 2'b01; board_in = b;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_busy", 256'(busy), 256'(0));
      check("mid_rst_board", board_out, 256'(0));
      check("mid_rst_done", 256'(done), 256'(0));
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("mid_rst_no_done", 256'(ndone), 256'(0));
      b = put(put(put(256'(0), 0, 0, 16'd2), 0, 1, 16'd2), 0, 2, 16'd4);
      exp = put(put(256'(0), 0, 0, 16'd4), 0, 1, 16'd4);
      run_move(2'b01, b, lat);
      check("post_rst_board", board_out, exp);
      check("post_rst_score", 256'(score_delta), 256'(4));
      check("post_rst_latency", 256'(lat), 256'(5));

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end

endmodule
